// File: rtl/mul_pkg.sv
// Shared types for the multiplier scheduler: FSM state encoding and default operand width.
package mul_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
  localparam int MUL_WIDTH_DEF = 32;
endpackage

// File: rtl/mul_shift_add_core.sv
// Shift-add datapath, one partial product per step; load takes 1 edge, no backpressure.
// acc and mplier_zero describe the state as it will be after the current step.
module mul_shift_add_core
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc,
  output logic               mplier_zero
);
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  // Post-step values let the FSM capture the final product on the last RUN edge.
  assign acc         = mplier[0] ? (acc_q + mcand) : acc_q;
  assign mplier_zero = (mplier >> 1) == '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load) begin
      acc_q  <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (step) begin
      acc_q  <= acc;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
endmodule

// File: rtl/mul_share_sched.sv
// Round-robin shared multiplier: product WIDTH edges after accept (fewer with EARLY_TERM_EN);
// holds the response while rsp_ready is low and grants nothing until it is taken.
module mul_share_sched
  import mul_pkg::*;
#(
  parameter  int NREQ  = 2,
  parameter  int WIDTH = MUL_WIDTH_DEF,
  localparam int IDW   = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*WIDTH-1:0]    rsp_z,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  mul_state_t         state;
  logic [CW-1:0]      count;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     grant;
  logic               grant_vld;
  logic               accept;
  logic               last_step;
  logic [2*WIDTH-1:0] acc;
  logic               mplier_zero;
  int                 idx;

  // Scan starts just after the last winner, so the previous grantee has lowest priority.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant     = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && !rst && grant_vld) req_ready[grant] = 1'b1;
  end

  assign accept    = (state == IDLE) && grant_vld;
  assign last_step = (count == CW'(WIDTH - 1)) || (EARLY && mplier_zero);
  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);

  mul_shift_add_core #(.WIDTH(WIDTH)) u_core (
    .clk         (clk),
    .rst         (rst),
    .load        (accept),
    .step        (state == RUN),
    .a           (req_a[int'(grant)*WIDTH +: WIDTH]),
    .b           (req_b[int'(grant)*WIDTH +: WIDTH]),
    .acc         (acc),
    .mplier_zero (mplier_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      ptr    <= IDW'(NREQ - 1);
      rsp_z  <= '0;
      rsp_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            count  <= '0;
            ptr    <= grant;
            rsp_id <= grant;
            state  <= RUN;
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (last_step) begin
            rsp_z <= acc;
            state <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
